async_bus_master: RTL and testbench

Synchronous initiator for the board-level asynchronous peripheral bus. It is the driving end of the interface whose slave-side decode produces my_wr, my_rd and the per-register chip selects.
- The slave decodes a write strobe as CS_=0, OE_=0, WR_=0, and a read strobe as CS_=0, OE_=0, WR_=1.
- It latches its register selects while CS_ is low and Addr is stable.
- This block turns single-cycle host requests into glitch-free, timed CS_/OE_/WR_/Addr/Data sequences, and returns read data plus a completion pulse.

---
 rtl/async_bus_master_if.sv | 32 +++
 rtl/async_bus_master.sv | 132 +++++++++++++
 tb/tb_async_bus_master.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/async_bus_master_if.sv
// Host request port and asynchronous peripheral bus pins of the bus master.
interface async_bus_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              CS_;
    logic              OE_;
    logic              WR_;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Data_out;
    logic              Data_oe;
    logic [DATA_W-1:0] Data_in;

    modport master (
        input  req, req_wr, req_addr, req_wdata, Data_in,
        output req_ready, done, rd_data,
        output CS_, OE_, WR_, Addr, Data_out, Data_oe
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, Data_in,
        input  req_ready, done, rd_data,
        input  CS_, OE_, WR_, Addr, Data_out, Data_oe
    );
endinterface

// File: rtl/async_bus_master.sv
// Turns single-cycle host requests into timed CS_/OE_/WR_ bus accesses.
module async_bus_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    async_bus_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam logic [3:0] CNT_SETUP  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] CNT_STROBE = 4'(STROBE_CYC - 1);
    localparam logic [3:0] CNT_HOLD   = 4'(HOLD_CYC - 1);

    state_t            r_state, w_state;
    logic [3:0]        r_cnt, w_cnt;
    logic              r_wr, w_wr;
    logic              r_cs_n, w_cs_n;
    logic              r_oe_n, w_oe_n;
    logic              r_wr_n, w_wr_n;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_dout, w_dout;
    logic              r_doe, w_doe;
    logic              r_done, w_done;
    logic [DATA_W-1:0] r_rd_data, w_rd_data;

    // Pin values are computed one cycle ahead so every output is a flop.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_wr      = r_wr;
        w_cs_n    = r_cs_n;
        w_oe_n    = r_oe_n;
        w_wr_n    = r_wr_n;
        w_addr    = r_addr;
        w_dout    = r_dout;
        w_doe     = r_doe;
        w_done    = 1'b0;
        w_rd_data = r_rd_data;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_state = S_SETUP;
                    w_cnt   = CNT_SETUP;
                    w_wr    = bus.req_wr;
                    w_cs_n  = 1'b0;
                    w_wr_n  = ~bus.req_wr;
                    w_addr  = bus.req_addr;
                    w_doe   = bus.req_wr;
                    if (bus.req_wr) w_dout = bus.req_wdata;
                end
            end
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_STROBE;
                    w_cnt   = CNT_STROBE;
                    w_oe_n  = 1'b0;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_HOLD;
                    w_cnt   = CNT_HOLD;
                    w_oe_n  = 1'b1;
                    if (!r_wr) w_rd_data = bus.Data_in;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_IDLE;
                    w_cs_n  = 1'b1;
                    w_wr_n  = 1'b1;
                    w_doe   = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_cs_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_addr    <= '0;
            r_dout    <= '0;
            r_doe     <= 1'b0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_wr      <= w_wr;
            r_cs_n    <= w_cs_n;
            r_oe_n    <= w_oe_n;
            r_wr_n    <= w_wr_n;
            r_addr    <= w_addr;
            r_dout    <= w_dout;
            r_doe     <= w_doe;
            r_done    <= w_done;
            r_rd_data <= w_rd_data;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.done      = r_done;
    assign bus.rd_data   = r_rd_data;
    assign bus.CS_       = r_cs_n;
    assign bus.OE_       = r_oe_n;
    assign bus.WR_       = r_wr_n;
    assign bus.Addr      = r_addr;
    assign bus.Data_out  = r_dout;
    assign bus.Data_oe   = r_doe;
endmodule

// File: tb/tb_async_bus_master.sv
// Directed bench: default-timing master plus a 3/4/2 timing master.
module tb_async_bus_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       req, req_wr;
    logic [7:0] req_addr, req_wdata, bus_val;
    int         sel;
    int         n_vec = 0;
    int         n_err = 0;

    logic       cs, oe, wrn, doe, done, rdy;
    logic [7:0] addr, dout, rdd;

    always #5 clk = ~clk;

    async_bus_master_if ifa ();
    async_bus_master_if ifb ();

    assign ifa.req       = req && (sel == 0);
    assign ifa.req_wr    = req_wr;
    assign ifa.req_addr  = req_addr;
    assign ifa.req_wdata = req_wdata;
    assign ifa.Data_in   = ifa.OE_ ? 8'hEE : bus_val;

    assign ifb.req       = req && (sel == 1);
    assign ifb.req_wr    = req_wr;
    assign ifb.req_addr  = req_addr;
    assign ifb.req_wdata = req_wdata;
    assign ifb.Data_in   = ifb.OE_ ? 8'hEE : bus_val;

    async_bus_master u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    async_bus_master #(
        .SETUP_CYC  (3),
        .STROBE_CYC (4),
        .HOLD_CYC   (2)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        if (sel == 0) begin
            cs = ifa.CS_; oe = ifa.OE_; wrn = ifa.WR_;
            doe = ifa.Data_oe; done = ifa.done; rdy = ifa.req_ready;
            addr = ifa.Addr; dout = ifa.Data_out; rdd = ifa.rd_data;
        end else begin
            cs = ifb.CS_; oe = ifb.OE_; wrn = ifb.WR_;
            doe = ifb.Data_oe; done = ifb.done; rdy = ifb.req_ready;
            addr = ifb.Addr; dout = ifb.Data_out; rdd = ifb.rd_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        snap();
    endtask

    task automatic issue(input logic wr, input logic [7:0] a,
                         input logic [7:0] wd);
        req = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    endtask

    // Caller has already issued the request; first tick is the accept edge.
    task automatic access(input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] rd_exp,
                          input int s, input int t, input int h,
                          input bit chain, input logic nwr,
                          input logic [7:0] na, input logic [7:0] nwd);
        logic [7:0] rd_prev, p_addr;
        logic       p_oe, p_wrn, oe_e;
        logic       my_wr, my_rd, reg1, reg2;
        snap();
        rd_prev = rdd;
        bus_val = rd_exp;
        tick();
        if (chain) issue(nwr, na, nwd);
        else req = 1'b0;
        p_oe = 1'b1; p_wrn = 1'b1; p_addr = 8'h00;
        for (int k = 1; k <= s + t + h; k++) begin
            if (k > 1) tick();
            oe_e = !(k > s && k <= s + t);
            chk("ctl", {26'd0, cs, oe, wrn, doe, done, rdy},
                {26'd0, 1'b0, oe_e, !wr, wr, 1'b0, 1'b0});
            chk("addr", {24'd0, addr}, {24'd0, a});
            if (wr) chk("dout", {24'd0, dout}, {24'd0, wd});
            if (k > 1 && (!p_oe || !oe))
                chk("stable", {23'd0, wrn, addr}, {23'd0, p_wrn, p_addr});
            if (!oe_e) begin
                my_wr = !cs && !oe && !wrn;
                my_rd = !cs && !oe && wrn;
                reg1  = !cs && addr == 8'hF0;
                reg2  = !cs && addr == 8'h0F;
                chk("decode", {28'd0, my_wr, my_rd, reg1, reg2},
                    {28'd0, wr, !wr, a == 8'hF0, a == 8'h0F});
            end
            p_oe = oe; p_wrn = wrn; p_addr = addr;
        end
        tick();
        chk("done", {26'd0, cs, oe, wrn, doe, done, rdy}, 32'h3B);
        chk("rd_data", {24'd0, rdd}, {24'd0, wr ? rd_prev : rd_exp});
        if (!chain) begin
            tick();
            chk("done_1cyc", {31'd0, done}, 32'd0);
            chk("rd_keep", {24'd0, rdd}, {24'd0, wr ? rd_prev : rd_exp});
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = 8'h00;
        req_wdata = 8'h00; bus_val = 8'h00; sel = 0;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle", {26'd0, cs, oe, wrn, doe, done, rdy}, 32'h39);
            chk("idle_addr", {24'd0, addr}, 32'd0);
        end
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_rd", {24'd0, rdd}, 32'd0);

        issue(1'b1, 8'hF0, 8'h5A);
        access(1'b1, 8'hF0, 8'h5A, 8'h00, 1, 2, 1, 1'b0, 1'b0, 8'h00, 8'h00);

        issue(1'b0, 8'h0F, 8'h00);
        access(1'b0, 8'h0F, 8'h00, 8'hC3, 1, 2, 1, 1'b0, 1'b0, 8'h00, 8'h00);

        issue(1'b1, 8'hA2, 8'h3C);
        access(1'b1, 8'hA2, 8'h3C, 8'h00, 1, 2, 1, 1'b1, 1'b0, 8'hF0, 8'h00);
        access(1'b0, 8'hF0, 8'h00, 8'h96, 1, 2, 1, 1'b0, 1'b0, 8'h00, 8'h00);

        issue(1'b1, 8'h0F, 8'h77);
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("strobe2", {30'd0, cs, oe}, 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_mid", {26'd0, cs, oe, wrn, doe, done, rdy}, 32'h39);
        chk("rst_mid_rd", {24'd0, rdd}, 32'd0);
        rst = 1'b0;
        issue(1'b0, 8'h0F, 8'h00);
        access(1'b0, 8'h0F, 8'h00, 8'h5E, 1, 2, 1, 1'b0, 1'b0, 8'h00, 8'h00);

        sel = 1;
        issue(1'b0, 8'h0F, 8'h00);
        access(1'b0, 8'h0F, 8'h00, 8'hA5, 3, 4, 2, 1'b0, 1'b0, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
